// File: rtl/display_scheduler.sv
// display_scheduler
// Shares the single seven-segment output path among operand A, operand B and
// the ALU result. Grants one source at a time (result > B > A) and holds the
// granted value for at least HOLD_CYCLES cycles before accepting a new grant.
//
// Optional feature: define DISPLAY_BLINK_EN to blink the display (via
// disp_blank) while a result granted with ovf=1 is shown. Without the macro
// ovf is ignored and disp_blank is high only in IDLE.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   req[2:0]   in   level requests: [0] A, [1] B, [2] result
//   data_a/b/r in   8-bit two's-complement source values
//   ovf        in   result overflow flag, sampled on a result grant
//   ack[2:0]   out  one-hot, one-cycle grant acknowledge
//   disp_val   out  value to the output unit
//   disp_src   out  0 none, 1 A, 2 B, 3 result
//   disp_blank out  1 = force all digits off
//   busy       out  1 while the dwell timer runs
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES  = 25_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic [7:0] data_r,
  input  logic       ovf,
  output logic [2:0] ack,
  output logic [7:0] disp_val,
  output logic [1:0] disp_src,
  output logic       disp_blank,
  output logic       busy
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_OPEN = 2'd2;

  logic [1:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [2:0]       nxt_ack;
  logic [7:0]       nxt_val;
  logic [1:0]       nxt_src;
  logic             nxt_blank, nxt_busy;
  logic             grant;

  // A grant happens whenever the dwell window is open and anyone requests.
  assign grant = (state != S_HOLD) && (|req);

`ifdef DISPLAY_BLINK_EN
  logic             ovf_lat, nxt_ovf_lat;
  logic [CNT_W-1:0] bcnt, nxt_bcnt;
`else
  logic unused_blink;
  assign unused_blink = ovf ^ (BLINK_CYCLES == 0);
`endif

  // Next-state and next-output logic.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_ack   = 3'b000;
    nxt_val   = disp_val;
    nxt_src   = disp_src;
    nxt_blank = disp_blank;
    nxt_busy  = busy;
`ifdef DISPLAY_BLINK_EN
    nxt_ovf_lat = ovf_lat;
    nxt_bcnt    = bcnt;
`endif

    if (grant) begin
      nxt_state = S_HOLD;
      nxt_busy  = 1'b1;
      nxt_cnt   = '0;
      nxt_blank = 1'b0;
      if (req[2]) begin
        nxt_ack = 3'b100;
        nxt_val = data_r;
        nxt_src = 2'd3;
      end else if (req[1]) begin
        nxt_ack = 3'b010;
        nxt_val = data_b;
        nxt_src = 2'd2;
      end else begin
        nxt_ack = 3'b001;
        nxt_val = data_a;
        nxt_src = 2'd1;
      end
`ifdef DISPLAY_BLINK_EN
      nxt_ovf_lat = req[2] & ovf;
      nxt_bcnt    = '0;
`endif
    end else if (state == S_HOLD) begin
      if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
        nxt_state = S_OPEN;
        nxt_busy  = 1'b0;
      end else begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end

`ifdef DISPLAY_BLINK_EN
    // Blink keeps running through OPEN until the next grant clears it.
    if (!grant && ovf_lat && (disp_src == 2'd3)) begin
      if (bcnt == CNT_W'(BLINK_CYCLES - 1)) begin
        nxt_bcnt  = '0;
        nxt_blank = ~disp_blank;
      end else begin
        nxt_bcnt = bcnt + CNT_W'(1);
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ack        <= 3'b000;
      disp_val   <= 8'h00;
      disp_src   <= 2'd0;
      disp_blank <= 1'b1;
      busy       <= 1'b0;
`ifdef DISPLAY_BLINK_EN
      ovf_lat    <= 1'b0;
      bcnt       <= '0;
`endif
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      ack        <= nxt_ack;
      disp_val   <= nxt_val;
      disp_src   <= nxt_src;
      disp_blank <= nxt_blank;
      busy       <= nxt_busy;
`ifdef DISPLAY_BLINK_EN
      ovf_lat    <= nxt_ovf_lat;
      bcnt       <= nxt_bcnt;
`endif
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
// Directed bench for display_scheduler with HOLD_CYCLES=4, BLINK_CYCLES=2.
// Expected grants are queued when requests are driven and checked when ack
// appears. Blink expectations follow DISPLAY_BLINK_EN.
module tb_display_scheduler;

  localparam int unsigned HOLD  = 4;
  localparam int unsigned BLINK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [7:0] data_a, data_b, data_r;
  logic       ovf;
  logic [2:0] ack;
  logic [7:0] disp_val;
  logic [1:0] disp_src;
  logic       disp_blank;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] ack;
    logic [7:0] val;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];

  display_scheduler #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data_a(data_a), .data_b(data_b), .data_r(data_r), .ovf(ovf),
    .ack(ack), .disp_val(disp_val), .disp_src(disp_src),
    .disp_blank(disp_blank), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_blank"}, 32'(disp_blank), 32'd1);
    check({tag, "_val"},   32'(disp_val),   32'h00);
    check({tag, "_src"},   32'(disp_src),   32'd0);
    check({tag, "_ack"},   32'(ack),        32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  // Waits for the next ack within a budget and compares against the queue head.
  task automatic wait_grant(input string tag, input int lat_exp);
    int   lat;
    exp_t e;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (ack != 3'b000) break;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(ack), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_ack"},     32'(ack),        32'(e.ack));
      check({tag, "_val"},     32'(disp_val),   32'(e.val));
      check({tag, "_src"},     32'(disp_src),   32'(e.src));
      check({tag, "_latency"}, 32'(lat),        32'(lat_exp));
      check({tag, "_blank"},   32'(disp_blank), 32'd0);
      check({tag, "_busy"},    32'(busy),       32'd1);
    end
  endtask

  function automatic logic blink_exp(input int off);
`ifdef DISPLAY_BLINK_EN
    return 1'(((off / BLINK) % 2));
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    reset = 1'b1; req = 3'b000; ovf = 1'b0;
    data_a = 8'h00; data_b = 8'h00; data_r = 8'h00;

    // Reset state
    tick(); tick();
    check_reset_vals("reset");
    reset = 1'b0;

    // Single grant from IDLE
    data_a = 8'hF9; req = 3'b001;
    exp_q.push_back('{3'b001, 8'hF9, 2'd1});
    wait_grant("single", 1);
    // Dropped request and data change during HOLD
    req = 3'b001; data_a = 8'h33;
    tick();
    check("drop_ack_c1", 32'(ack), 32'd0);
    check("drop_busy_c1", 32'(busy), 32'd1);
    req = 3'b000;
    tick();
    check("drop_busy_c2", 32'(busy), 32'd1);
    tick();
    check("drop_busy_c3", 32'(busy), 32'd1);
    tick();
    check("drop_busy_c4", 32'(busy), 32'd0);
    check("drop_ack_c4", 32'(ack), 32'd0);
    tick(); tick();
    check("hold_val", 32'(disp_val), 32'hF9);
    check("hold_src", 32'(disp_src), 32'd1);
    check("hold_ack", 32'(ack), 32'd0);

    // Priority: result, then B, then A, spaced HOLD+1 cycles
    data_r = 8'h64; data_b = 8'h05; data_a = 8'hFF; req = 3'b111;
    exp_q.push_back('{3'b100, 8'h64, 2'd3});
    exp_q.push_back('{3'b010, 8'h05, 2'd2});
    exp_q.push_back('{3'b001, 8'hFF, 2'd1});
    wait_grant("prio_r", 1);
    req = 3'b011;
    tick();
    check("prio_ack_pulse", 32'(ack), 32'd0);
    wait_grant("prio_b", int'(HOLD));
    req = 3'b001;
    wait_grant("prio_a", int'(HOLD) + 1);
    req = 3'b000;
    for (int i = 0; i < int'(HOLD); i++) tick();
    check("prio_end_busy", 32'(busy), 32'd0);

    // Reset mid-HOLD with B request held
    data_b = 8'h22; req = 3'b010;
    exp_q.push_back('{3'b010, 8'h22, 2'd2});
    wait_grant("pre_rst", 1);
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midhold_rst");
    reset = 1'b0;
    exp_q.push_back('{3'b010, 8'h22, 2'd2});
    wait_grant("post_rst", 1);
    req = 3'b000;
    for (int i = 0; i < int'(HOLD) + 1; i++) tick();

    // Simultaneous reset and request: reset wins
    reset = 1'b1; req = 3'b001;
    tick();
    check_reset_vals("rst_req");
    reset = 1'b0; req = 3'b000;
    tick();

    // Overflow result: blink pattern when enabled, steady otherwise
    data_r = 8'h80; ovf = 1'b1; req = 3'b100;
    exp_q.push_back('{3'b100, 8'h80, 2'd3});
    wait_grant("ovf_grant", 1);
    req = 3'b000; ovf = 1'b0;
    for (int off = 1; off <= 7; off++) begin
      tick();
      check($sformatf("blink_off%0d", off), 32'(disp_blank), 32'(blink_exp(off)));
    end
    check("blink_val", 32'(disp_val), 32'h80);

    // Next grant clears the blink
    data_a = 8'h12; req = 3'b001;
    exp_q.push_back('{3'b001, 8'h12, 2'd1});
    wait_grant("clear_grant", 1);
    req = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("steady_blank%0d", i), 32'(disp_blank), 32'd0);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
